// File: rtl/tick_scheduler_pkg.sv
// tick_scheduler_pkg
// Shared types and constants for the tick scheduler.
//   state_t            : scheduler state (STOP / RUN)
//   DEFAULT_DIV_VALUE  : divisor loaded at reset unless overridden
//   MIN/MAX_CLIENTS    : legal range for the number of requesters
//   num_clients_ok()   : range check used at elaboration
package tick_scheduler_pkg;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_DIV_VALUE = 9;
    localparam int MIN_CLIENTS       = 2;
    localparam int MAX_CLIENTS       = 8;

    function automatic bit num_clients_ok(input int n);
        return (n >= MIN_CLIENTS) && (n <= MAX_CLIENTS);
    endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if
// Control and tick-distribution signals of the tick scheduler.
//   enable     : run request (level)
//   div_value  : new divisor, tick period is div_value+1 cycles
//   div_load   : single-cycle strobe capturing div_value
//   req        : per-client tick request (level, sampled at wraps)
//   tick       : one-cycle pulse per period
//   grant      : one-hot (or zero) client owning the current tick
//   running    : high while the scheduler is in RUN
// master = the controlling/consuming side, slave = the scheduler.
interface tick_scheduler_if #(
    parameter int DIV_WIDTH   = 16,
    parameter int NUM_CLIENTS = 4
);
    logic                   enable;
    logic [DIV_WIDTH-1:0]   div_value;
    logic                   div_load;
    logic [NUM_CLIENTS-1:0] req;
    logic                   tick;
    logic [NUM_CLIENTS-1:0] grant;
    logic                   running;

    modport master (
        output enable, div_value, div_load, req,
        input  tick, grant, running
    );

    modport slave (
        input  enable, div_value, div_load, req,
        output tick, grant, running
    );
endinterface

// File: rtl/tick_scheduler_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick. Clients are scanned starting at ptr+1
// (modulo NUM_CLIENTS); the first one with req high wins.
//   req   : request vector
//   ptr   : last granted client
//   grant : one-hot winner (zero when nobody requests)
//   valid : a winner exists
//   idx   : index of the winner (meaningful only when valid)
module rr_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int PTR_W       = 2
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [PTR_W-1:0]       ptr,
    output logic [NUM_CLIENTS-1:0] grant,
    output logic                   valid,
    output logic [PTR_W-1:0]       idx
);

    localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(NUM_CLIENTS);

    logic [PTR_W-1:0]       cand [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] hit;

    // cand[gi] is the client examined at scan position gi (0 = highest priority).
    // ptr+gi+1 never reaches 2*NUM_CLIENTS, so one conditional subtract wraps it.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_scan
            logic [PTR_W:0] sum;
            assign sum      = {1'b0, ptr} + (PTR_W+1)'(gi + 1);
            assign cand[gi] = (sum >= N_EXT) ? PTR_W'(sum - N_EXT) : PTR_W'(sum);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    // Walk from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            if (hit[k]) begin
                valid = 1'b1;
                idx   = cand[k];
            end
        end
        if (valid) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler
// Divides the fabric clock into a programmable periodic tick and hands each
// tick to one requesting client, round-robin. Consumers gate their logic
// with their grant bit instead of using derived clocks.
//   clock   : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : tick_scheduler_if.slave (enable, div_value, div_load, req in;
//             tick, grant, running out -- all outputs registered)
module tick_scheduler
    import tick_scheduler_pkg::*;
#(
    parameter int DIV_WIDTH   = 16,
    parameter int NUM_CLIENTS = 4,
    parameter int DEFAULT_DIV = DEFAULT_DIV_VALUE
) (
    input  logic           clock,
    input  logic           reset_n,
    tick_scheduler_if.slave bus
);

    localparam int                   PTR_W    = $clog2(NUM_CLIENTS);
    localparam logic [DIV_WIDTH-1:0] DIV_RST  = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [PTR_W-1:0]     PTR_RST  = PTR_W'(NUM_CLIENTS - 1);

    generate
        if (!num_clients_ok(NUM_CLIENTS)) begin : g_bad_num_clients
            $error("tick_scheduler: NUM_CLIENTS must be in 2..8");
        end
    endgenerate

    state_t                 state_reg,      state_next;
    logic [DIV_WIDTH-1:0]   div_reg,        div_next;
    logic [DIV_WIDTH-1:0]   pend_reg,       pend_next;
    logic                   pend_valid_reg, pend_valid_next;
    logic [DIV_WIDTH-1:0]   count_reg,      count_next;
    logic [PTR_W-1:0]       ptr_reg,        ptr_next;
    logic                   tick_reg,       tick_next;
    logic [NUM_CLIENTS-1:0] grant_reg,      grant_next;
    logic                   running_reg,    running_next;

    logic [NUM_CLIENTS-1:0] arb_grant;
    logic                   arb_valid;
    logic [PTR_W-1:0]       arb_idx;
    logic [DIV_WIDTH-1:0]   reload_div;

    rr_arbiter #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .PTR_W       (PTR_W)
    ) u_arb (
        .req   (bus.req),
        .ptr   (ptr_reg),
        .grant (arb_grant),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    // A divisor loaded earlier in this period takes effect at the wrap.
    assign reload_div = pend_valid_reg ? pend_reg : div_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= STOP;
            div_reg        <= DIV_RST;
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            count_reg      <= DIV_RST;
            ptr_reg        <= PTR_RST;
            tick_reg       <= 1'b0;
            grant_reg      <= '0;
            running_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            div_reg        <= div_next;
            pend_reg       <= pend_next;
            pend_valid_reg <= pend_valid_next;
            count_reg      <= count_next;
            ptr_reg        <= ptr_next;
            tick_reg       <= tick_next;
            grant_reg      <= grant_next;
            running_reg    <= running_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        div_next        = div_reg;
        pend_next       = pend_reg;
        pend_valid_next = pend_valid_reg;
        count_next      = count_reg;
        ptr_next        = ptr_reg;
        tick_next       = 1'b0;
        grant_next      = '0;

        case (state_reg)
            STOP: begin
                // While stopped the counter always mirrors the divisor, so
                // entering RUN needs no separate reload.
                if (bus.div_load) begin
                    div_next        = bus.div_value;
                    count_next      = bus.div_value;
                    pend_valid_next = 1'b0;
                end
                if (bus.enable) begin
                    state_next = RUN;
                end
            end

            RUN: begin
                if (bus.div_load) begin
                    pend_next       = bus.div_value;
                    pend_valid_next = 1'b1;
                end
                if (!bus.enable) begin
                    // Stop wins over a wrap on the same edge: no tick.
                    state_next = STOP;
                    count_next = div_reg;
                end else if (count_reg == '0) begin
                    div_next        = reload_div;
                    count_next      = reload_div;
                    // A load on the wrap edge becomes pending for the next period.
                    pend_valid_next = bus.div_load;
                    tick_next       = 1'b1;
                    grant_next      = arb_grant;
                    if (arb_valid) begin
                        ptr_next = arb_idx;
                    end
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end

            default: begin
                state_next = STOP;
            end
        endcase

        running_next = (state_next == RUN);
    end

    assign bus.tick    = tick_reg;
    assign bus.grant   = grant_reg;
    assign bus.running = running_reg;

endmodule

// File: tb/tb_tick_scheduler.sv
module tb_tick_scheduler;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int DEF = 9;

    logic clock;
    logic reset_n;

    tick_scheduler_if #(.DIV_WIDTH(DW), .NUM_CLIENTS(N)) bus ();

    tick_scheduler #(
        .DIV_WIDTH   (DW),
        .NUM_CLIENTS (N),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors;
    int miscompares;

    // Behavioural reference: phase counts cycles since the period started,
    // a tick fires when phase reaches the period length.
    bit         m_run;
    int         m_phase;
    int         m_period;
    bit         m_pend_valid;
    int         m_pend;
    int         m_ptr;
    logic       exp_tick;
    logic [N-1:0] exp_grant;
    logic       exp_running;

    task automatic model_reset();
        m_run        = 1'b0;
        m_phase      = 0;
        m_period     = DEF;
        m_pend_valid = 1'b0;
        m_pend       = 0;
        m_ptr        = N - 1;
        exp_tick     = 1'b0;
        exp_grant    = '0;
        exp_running  = 1'b0;
    endtask

    task automatic model_edge(input bit en, input bit ld, input int dv, input logic [N-1:0] rq);
        bit found;
        int c;
        exp_tick  = 1'b0;
        exp_grant = '0;
        if (!m_run) begin
            if (ld) begin
                m_period     = dv;
                m_pend_valid = 1'b0;
            end
            if (en) begin
                m_run   = 1'b1;
                m_phase = 0;
            end
        end else if (!en) begin
            m_run = 1'b0;
            if (ld) begin
                m_pend       = dv;
                m_pend_valid = 1'b1;
            end
        end else if (m_phase == m_period) begin
            exp_tick = 1'b1;
            found    = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && rq[c]) begin
                    exp_grant[c] = 1'b1;
                    m_ptr        = c;
                    found        = 1'b1;
                end
            end
            m_phase = 0;
            if (m_pend_valid) m_period = m_pend;
            m_pend_valid = ld;
            if (ld) m_pend = dv;
        end else begin
            m_phase++;
            if (ld) begin
                m_pend       = dv;
                m_pend_valid = 1'b1;
            end
        end
        exp_running = m_run;
    endtask

    // One clock edge: model sees the same sampled inputs, outputs settle by +1.
    task automatic cycle();
        @(posedge clock);
        model_edge(bus.enable, bus.div_load, int'(bus.div_value), bus.req);
        #1;
        bus.div_load = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (bus.tick !== 1'b0 || bus.grant !== '0 || bus.running !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got tick=%b grant=%b running=%b want 0/0000/0",
                     bus.tick, bus.grant, bus.running);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            vectors++;
            if (bus.tick !== exp_tick || bus.grant !== exp_grant || bus.running !== exp_running) begin
                miscompares++;
                $display("FAIL reset_idle got %b/%b/%b want %b/%b/%b",
                         bus.tick, bus.grant, bus.running, exp_tick, exp_grant, exp_running);
            end
        end
    endtask

    task automatic test_period();
        int ticks[$];
        bus.enable = 1'b1;
        cycle();
        vectors++;
        if (bus.running !== 1'b1) begin
            miscompares++;
            $display("FAIL running_rise got %b want 1", bus.running);
        end
        for (int j = 1; j <= 35; j++) begin
            cycle();
            vectors++;
            if (bus.tick !== exp_tick || bus.grant !== exp_grant || bus.running !== exp_running) begin
                miscompares++;
                $display("FAIL period j=%0d got %b/%b/%b want %b/%b/%b", j,
                         bus.tick, bus.grant, bus.running, exp_tick, exp_grant, exp_running);
            end
            if (bus.tick === 1'b1) begin
                ticks.push_back(j);
                $display("period: tick %0d edges after enable", j);
            end
        end
        vectors++;
        if (ticks.size() != 3 || ticks[0] != 10 || ticks[1] != 20 || ticks[2] != 30) begin
            miscompares++;
            $display("FAIL period_positions got %0d ticks (first %0d) want 3 at 10,20,30",
                     ticks.size(), (ticks.size() > 0) ? ticks[0] : -1);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want [5];
        logic [N-1:0] seen [$];
        want[0] = 4'b0001; want[1] = 4'b0010; want[2] = 4'b0100;
        want[3] = 4'b1000; want[4] = 4'b0001;
        bus.req = 4'b1111;
        for (int i = 0; i < 70 && seen.size() < 5; i++) begin
            cycle();
            vectors++;
            if (bus.tick !== exp_tick || bus.grant !== exp_grant || bus.running !== exp_running) begin
                miscompares++;
                $display("FAIL rr_cycle got %b/%b/%b want %b/%b/%b",
                         bus.tick, bus.grant, bus.running, exp_tick, exp_grant, exp_running);
            end
            if (bus.tick === 1'b1) begin
                seen.push_back(bus.grant);
                $display("round_robin: grant=%b", bus.grant);
            end
        end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (k >= seen.size()) begin
                miscompares++;
                $display("FAIL rr_timeout tick %0d never seen want grant %b", k, want[k]);
            end else if (seen[k] !== want[k]) begin
                miscompares++;
                $display("FAIL rr_seq[%0d] got %b want %b", k, seen[k], want[k]);
            end
        end
    endtask

    task automatic test_no_req();
        logic [N-1:0] reqs [3];
        logic [N-1:0] want [3];
        bit           got;
        reqs[0] = 4'b0000; want[0] = 4'b0000;
        reqs[1] = 4'b0100; want[1] = 4'b0100;
        reqs[2] = 4'b1111; want[2] = 4'b1000;
        for (int t = 0; t < 3; t++) begin
            bus.req = reqs[t];
            got = 1'b0;
            for (int i = 0; i < 15 && !got; i++) begin
                cycle();
                vectors++;
                if (bus.tick !== exp_tick || bus.grant !== exp_grant || bus.running !== exp_running) begin
                    miscompares++;
                    $display("FAIL noreq_cycle got %b/%b/%b want %b/%b/%b",
                             bus.tick, bus.grant, bus.running, exp_tick, exp_grant, exp_running);
                end
                if (bus.tick === 1'b1) begin
                    got = 1'b1;
                    $display("no_req: req=%b grant=%b", reqs[t], bus.grant);
                    vectors++;
                    if (bus.grant !== want[t]) begin
                        miscompares++;
                        $display("FAIL noreq_grant[%0d] got %b want %b", t, bus.grant, want[t]);
                    end
                end
            end
            vectors++;
            if (!got) begin
                miscompares++;
                $display("FAIL noreq_timeout[%0d] tick=0 want a tick within 15 cycles", t);
            end
        end
    endtask

    task automatic test_div_change();
        int gaps[$];
        int cnt;
        bit got;
        // Previous test left us in the cycle right after a wrap.
        cnt = 0;
        for (int i = 0; i < 60 && gaps.size() < 3; i++) begin
            if (i == 2) begin
                bus.div_load  = 1'b1;
                bus.div_value = 16'd2;
            end
            cycle();
            vectors++;
            if (bus.tick !== exp_tick || bus.grant !== exp_grant || bus.running !== exp_running) begin
                miscompares++;
                $display("FAIL div_cycle got %b/%b/%b want %b/%b/%b",
                         bus.tick, bus.grant, bus.running, exp_tick, exp_grant, exp_running);
            end
            cnt++;
            if (bus.tick === 1'b1) begin
                gaps.push_back(cnt);
                $display("div_change: period %0d", cnt);
                cnt = 0;
            end
        end
        vectors++;
        if (gaps.size() != 3 || gaps[0] != 10 || gaps[1] != 3 || gaps[2] != 3) begin
            miscompares++;
            $display("FAIL div_gaps got %0d gaps (first %0d) want 10,3,3",
                     gaps.size(), (gaps.size() > 0) ? gaps[0] : -1);
        end
        // Divisor 0: tick every cycle once the pending value lands.
        bus.div_load  = 1'b1;
        bus.div_value = 16'd0;
        got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            cycle();
            if (bus.tick === 1'b1) got = 1'b1;
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            vectors++;
            if (bus.tick !== 1'b1 || bus.tick !== exp_tick || bus.grant !== exp_grant) begin
                miscompares++;
                $display("FAIL div_zero[%0d] got tick=%b grant=%b want tick=1 grant=%b",
                         i, bus.tick, bus.grant, exp_grant);
            end
        end
    endtask

    task automatic test_stop_on_wrap();
        int cnt;
        bit got;
        // Divisor is 0, so this edge is also a wrap edge.
        bus.enable = 1'b0;
        cycle();
        vectors++;
        if (bus.tick !== 1'b0 || bus.running !== 1'b0 || bus.grant !== '0) begin
            miscompares++;
            $display("FAIL stop_wrap0 got tick=%b running=%b grant=%b want 0/0/0",
                     bus.tick, bus.running, bus.grant);
        end
        bus.div_load  = 1'b1;
        bus.div_value = 16'd4;
        cycle();
        bus.enable = 1'b1;
        cycle();
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            cycle();
            if (bus.tick === 1'b1) got = 1'b1;
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL stop_sync tick=0 want a tick within 10 cycles");
        end
        for (int i = 0; i < 4; i++) cycle();
        bus.enable = 1'b0;
        cycle();
        vectors++;
        if (bus.tick !== 1'b0 || bus.running !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_wrap got tick=%b running=%b want 0/0", bus.tick, bus.running);
        end
        bus.req    = 4'b1111;
        bus.enable = 1'b1;
        cycle();
        cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            cycle();
            cnt++;
            if (bus.tick === 1'b1) begin
                got = 1'b1;
                $display("stop_on_wrap: re-enabled tick after %0d, grant=%b", cnt, bus.grant);
                vectors++;
                if (cnt != 5 || bus.grant !== exp_grant || bus.tick !== exp_tick) begin
                    miscompares++;
                    $display("FAIL reenable got gap=%0d grant=%b want gap=5 grant=%b",
                             cnt, bus.grant, exp_grant);
                end
            end
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL reenable_timeout tick=0 want a tick within 12 cycles");
        end
    endtask

    task automatic test_async_reset();
        int gaps[$];
        int cnt;
        // Divisor 4 running; queue a pending 7 mid-period.
        cycle();
        bus.div_load  = 1'b1;
        bus.div_value = 16'd7;
        cycle();
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.tick !== 1'b0 || bus.grant !== '0 || bus.running !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset got tick=%b grant=%b running=%b want 0/0000/0",
                     bus.tick, bus.grant, bus.running);
        end
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        cnt = 0;
        for (int i = 0; i < 40 && gaps.size() < 2; i++) begin
            cycle();
            vectors++;
            if (bus.tick !== exp_tick || bus.grant !== exp_grant || bus.running !== exp_running) begin
                miscompares++;
                $display("FAIL post_reset got %b/%b/%b want %b/%b/%b",
                         bus.tick, bus.grant, bus.running, exp_tick, exp_grant, exp_running);
            end
            cnt++;
            if (bus.tick === 1'b1) begin
                gaps.push_back(cnt);
                $display("async_reset: tick after %0d", cnt);
                cnt = 0;
            end
        end
        vectors++;
        if (gaps.size() != 2 || gaps[0] != 11 || gaps[1] != 10) begin
            miscompares++;
            $display("FAIL reset_period got %0d gaps (first %0d) want 11,10",
                     gaps.size(), (gaps.size() > 0) ? gaps[0] : -1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            bus.enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) begin
                bus.div_load  = 1'b1;
                bus.div_value = 16'($urandom_range(0, 6));
            end
            bus.req = 4'($urandom_range(0, 15));
            cycle();
            vectors++;
            if (bus.tick !== exp_tick || bus.grant !== exp_grant || bus.running !== exp_running) begin
                miscompares++;
                $display("FAIL random i=%0d got %b/%b/%b want %b/%b/%b", i,
                         bus.tick, bus.grant, bus.running, exp_tick, exp_grant, exp_running);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset_n       = 1'b0;
        bus.enable    = 1'b0;
        bus.div_load  = 1'b0;
        bus.div_value = '0;
        bus.req       = '0;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        test_reset();
        test_period();
        test_round_robin();
        test_no_req();
        test_div_change();
        test_stop_on_wrap();
        test_async_reset();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
